// File: rtl/bus_dev_pkg.sv
// Shared definitions for the bus device endpoint.
//   ID_W / BROADCAST : destination-ID field width and the wildcard ID.
//   sat_cnt_t        : 8-bit saturating event counter type.
//   dest_of()        : extracts the destination ID from the top of a packet.
//   sat_inc()        : increments a sat_cnt_t, holding at its maximum.
package bus_dev_pkg;

  localparam int ID_W      = 8;
  localparam int PKT_MAX_W = 64;
  localparam logic [ID_W-1:0] BROADCAST = 8'hFF;

  localparam int CNT_W = 8;
  typedef logic [CNT_W-1:0] sat_cnt_t;

  // pkt is the packet zero-extended to PKT_MAX_W; pkt_w is its real width.
  function automatic logic [ID_W-1:0] dest_of(input logic [PKT_MAX_W-1:0] pkt,
                                              input int unsigned          pkt_w);
    logic [PKT_MAX_W-1:0] sh;
    sh = pkt >> (pkt_w - ID_W);
    return sh[ID_W-1:0];
  endfunction

  function automatic sat_cnt_t sat_inc(input sat_cnt_t c);
    return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Register-based synchronous FIFO with first-word-fall-through output.
// Depth may be any integer >= 2; pointers wrap explicitly at depth-1.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   wr_en, wr_data  : write strobe / data (accepted if not full, or full with rd_en)
//   rd_en, rd_data  : read strobe / head entry (0 while empty)
//   full, empty     : occupancy flags
//   count           : occupancy, 0..depth
//   ovf, udf        : one-cycle pulses for a dropped write / ignored read
module sync_fifo_fwft
  import bus_dev_pkg::*;
#(
  parameter int width = 16,
  parameter int depth = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [width-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [width-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(depth+1)-1:0] count,
  output logic                       ovf,
  output logic                       udf
);

  localparam int PTR_W = $clog2(depth);
  localparam int OCC_W = $clog2(depth + 1);

  logic [width-1:0] mem_q [depth];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] count_q, count_d;
  logic             wr_acc, rd_acc;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count_q == OCC_W'(depth));
  assign empty = (count_q == '0);
  assign count = count_q;

  // A full queue still takes a write when the head leaves in the same cycle.
  assign wr_acc = wr_en && (!full || rd_en);
  assign rd_acc = rd_en && !empty;
  assign ovf    = wr_en && full && !rd_en;
  assign udf    = rd_en && empty;

  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = next_ptr(wr_ptr_q);
    if (rd_acc) rd_ptr_d = next_ptr(rd_ptr_q);
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the empty flag masks stale contents on rd_data.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/bus_dev_port.sv
// Per-device bus endpoint: a TX queue feeding the arbiter and an RX queue
// fed by the arbiter through a destination-ID filter.
// Ports:
//   clk, reset             : clock, asynchronous active-high reset
//   wr_en, wr_data         : host write into TX
//   tx_full, tx_count      : TX status
//   pndng, D_pop, pop      : arbiter side of TX (FWFT head, consume strobe)
//   push, D_push           : arbiter delivery into RX
//   rd_en, rd_data         : host read from RX (FWFT head)
//   rx_empty, rx_count     : RX status
//   tx_drop_cnt, rx_drop_cnt : saturating counts of writes lost to a full queue
//   err_flags              : sticky [0] pop-empty, [1] misrouted, [2] read-empty
module bus_dev_port
  import bus_dev_pkg::*;
#(
  parameter int              pckg_sz   = 16,
  parameter int              fifo_size = 8,
  parameter int              dev_id    = 0,
  parameter logic [ID_W-1:0] broadcast = BROADCAST
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wr_en,
  input  logic [pckg_sz-1:0]             wr_data,
  output logic                           tx_full,
  output logic [$clog2(fifo_size+1)-1:0] tx_count,
  output logic                           pndng,
  output logic [pckg_sz-1:0]             D_pop,
  input  logic                           pop,
  input  logic                           push,
  input  logic [pckg_sz-1:0]             D_push,
  input  logic                           rd_en,
  output logic [pckg_sz-1:0]             rd_data,
  output logic                           rx_empty,
  output logic [$clog2(fifo_size+1)-1:0] rx_count,
  output logic [7:0]                     tx_drop_cnt,
  output logic [7:0]                     rx_drop_cnt,
  output logic [2:0]                     err_flags
);

  logic            tx_empty, tx_ovf, tx_udf;
  logic            rx_full, rx_ovf, rx_udf;
  logic [ID_W-1:0] dest;
  logic            accept, misroute;

  sat_cnt_t   tx_drop_q, tx_drop_d;
  sat_cnt_t   rx_drop_q, rx_drop_d;
  logic [2:0] err_q, err_d;

  sync_fifo_fwft #(.width(pckg_sz), .depth(fifo_size)) u_tx (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (D_pop),
    .full    (tx_full),
    .empty   (tx_empty),
    .count   (tx_count),
    .ovf     (tx_ovf),
    .udf     (tx_udf)
  );

  assign pndng = !tx_empty;

  assign dest     = dest_of(PKT_MAX_W'(D_push), pckg_sz);
  assign accept   = push && ((dest == ID_W'(dev_id)) || (dest == broadcast));
  assign misroute = push && !accept;

  sync_fifo_fwft #(.width(pckg_sz), .depth(fifo_size)) u_rx (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (accept),
    .wr_data (D_push),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .full    (rx_full),
    .empty   (rx_empty),
    .count   (rx_count),
    .ovf     (rx_ovf),
    .udf     (rx_udf)
  );

  always_comb begin
    tx_drop_d = tx_ovf ? sat_inc(tx_drop_q) : tx_drop_q;
    rx_drop_d = rx_ovf ? sat_inc(rx_drop_q) : rx_drop_q;
    err_d     = err_q | {rx_udf, misroute, tx_udf};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_drop_q <= '0;
      rx_drop_q <= '0;
      err_q     <= '0;
    end else begin
      tx_drop_q <= tx_drop_d;
      rx_drop_q <= rx_drop_d;
      err_q     <= err_d;
    end
  end

  assign tx_drop_cnt = tx_drop_q;
  assign rx_drop_cnt = rx_drop_q;
  assign err_flags   = err_q;

endmodule

// File: doc/bus_dev_port.md
Name: bus_dev_port

Overview:
Per-device endpoint that sits directly on one port of the bus generator/arbiter (bs_gnrtr_n_rbtr) and replaces the behavioural fifo_in model in the bench. It contains two queues:
- TX queue: buffers host packets and presents them to the bus through pndng/D_pop/pop.
- RX queue: captures packets the bus delivers through push/D_push, after an address filter.
The arbiter instantiates one bus_dev_port per drvrs index.

Parameters:
pckg_sz, 16, packet width in bits; bits [pckg_sz-1 -: 8] hold the destination ID.
fifo_size, 8, depth of each queue in entries; must be ≥2; any integer is allowed, not only powers of two.
dev_id, 0, this device's 8-bit ID; must be less than drvrs.
broadcast, 8'hFF, destination ID accepted by every device.

Ports:
clk  in  1  bus clock; all state updates on its rising edge.
reset  in  1  asynchronous, active-high reset.
wr_en  in  1  host write strobe into the TX queue.
wr_data  in  pckg_sz  host packet to transmit.
tx_full  out  1  TX queue full.
tx_count  out  $clog2(fifo_size+1)  TX occupancy.
pndng  out  1  TX queue non-empty; goes to the arbiter.
D_pop  out  pckg_sz  TX head entry (first-word-fall-through); goes to the arbiter.
pop  in  1  arbiter consumes the TX head.
push  in  1  arbiter delivers a packet.
D_push  in  pckg_sz  delivered packet.
rd_en  in  1  host read strobe from the RX queue.
rd_data  out  pckg_sz  RX head entry (first-word-fall-through).
rx_empty  out  1  RX queue empty.
rx_count  out  $clog2(fifo_size+1)  RX occupancy.
tx_drop_cnt  out  8  TX writes lost because the queue was full; saturates at 255.
rx_drop_cnt  out  8  accepted deliveries lost because the RX queue was full; saturates at 255.
err_flags  out  3  sticky error flags: [0] pop while empty, [1] misrouted delivery, [2] rd_en while empty.

Behaviour:
Reset (asynchronous assert, synchronous release):
- Both queues empty; all pointers 0.
- pndng=0, tx_full=0, rx_empty=1, counts=0, drop counters=0, err_flags=0.
- D_pop and rd_data read 0 while their queue is empty.
- Reset asserted mid-operation discards all contents immediately, with no completion of in-flight transfers.

TX queue:
- A write is accepted when wr_en=1 and either tx_full=0 or pop=1 in the same cycle. When full with a same-cycle pop, count stays fifo_size.
- wr_en=1 while full without pop: data is dropped and tx_drop_cnt increments.
- Entries are stored in registers. D_pop = mem[rd_ptr], combinational from state, so a written entry is visible the cycle after the write edge.
- pndng = (tx_count != 0), derived from registered state.
- pop=1 while empty is ignored and sets err_flags[0]. This includes wr_en and pop in the same cycle on an empty queue: the write is accepted and the pop is ignored.
- Write pointer and read pointer each wrap from fifo_size-1 to 0.
- Latency: packet written at edge N appears on pndng/D_pop after edge N and may be popped at edge N+1.

RX queue:
- On push=1, let dest = D_push[pckg_sz-1 -: 8].
- If dest == dev_id or dest == broadcast, the delivery is accepted.
- Otherwise it is discarded and err_flags[1] is set.
- Accepted delivery while the RX queue is full and rd_en=0: dropped, rx_drop_cnt increments.
- Accepted delivery while full with rd_en=1 in the same cycle: stored.
- rd_en while empty is ignored and sets err_flags[2].
- rd_data follows the same FWFT rule as D_pop.

General:
- Counters saturate and never wrap.
- err_flags clear only on reset.
- Packet order within each queue is strictly FIFO.

Decomposition:
Package bus_dev_pkg holds:
- ID_W = 8.
- BROADCAST = 8'hFF.
- function dest_of(pkt): returns the top ID_W bits.
- parameterised typedef for the saturating 8-bit counter.

Sub-module sync_fifo_fwft, parameters (width, depth):
- Ports: clk, reset, wr_en, wr_data, rd_en, rd_data, full, empty, count, ovf, udf.
- ovf is a single-cycle pulse for a write dropped while full.
- udf is a single-cycle pulse for a read attempted while empty.
- Instantiated twice, once for TX and once for RX.
- The top level adds the address filter, saturating drop counters and sticky flags.

Test Plan:
1. Reset, then 3 writes 16'h0211, 16'h0322, 16'hFF33 with pop held 0.
   → pndng=1 from the edge after the first write; D_pop=16'h0211; tx_count=3.
   → pops return 0211, 0322, FF33 in that order; pndng=0 after the third pop.
2. Fill TX to 8 entries, write a 9th with pop=0 → tx_drop_cnt=1, count=8. Write a 10th with pop=1 → accepted, count=8, the 10th packet is last out.
3. dev_id=2: push D_push=16'h02AA, then 16'hFFBB, then 16'h01CC.
   → RX holds AA and BB packets only; rx_count=2; err_flags[1]=1.
4. Fill RX with 8 entries, then 300 further accepted pushes with rd_en=0.
   → rx_drop_cnt=255 (saturated); RX contents equal the first 8 packets.
5. pop with an empty TX; rd_en with an empty RX.
   → err_flags=3'b101; counts stay 0; no pointer movement.
6. Assert reset asynchronously between clock edges with TX count 5 and RX count 3.
   → outputs take reset values immediately, before the next clk edge; operation after release is normal.
